// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: nibble width,
// default digit count, width helper and the nibble-slice helper.
package seg_pkg;

    localparam int SEG_NIB_W   = 4;
    localparam int SEG_NUM_DIG = 6;
    localparam int SEG_MAX_DIG = 16;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } seg_phase_e;

    // Minimum one bit so single-value counters still get a real register.
    function automatic int seg_clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [SEG_NIB_W-1:0] seg_nib(
        input logic [SEG_NIB_W*SEG_MAX_DIG-1:0] vec,
        input int unsigned                      i
    );
        return vec[SEG_NIB_W*i +: SEG_NIB_W];
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler: cnt walks one digit slot, idx walks the digits of a frame.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int SLOT_CYC = 4,
    parameter int NUM_DIG  = SEG_NUM_DIG,
    parameter int CNT_W    = seg_clog2(SLOT_CYC),
    parameter int IDX_W    = seg_clog2(NUM_DIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] cnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             slot_wrap_o,
    output logic             frame_wrap_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        slot_wrap_o  = (cnt_q == CNT_W'(SLOT_CYC - 1));
        frame_wrap_o = slot_wrap_o && (idx_q == IDX_W'(NUM_DIG - 1));
        cnt_d        = slot_wrap_o ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        if (frame_wrap_o) begin
            idx_d = '0;
        end else if (slot_wrap_o) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign cnt_o = cnt_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-frame input snapshot.
// Optional leading-zero suppression: define SEG_SCAN_LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIG   = SEG_NUM_DIG,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int FRAME_HZ  = 200,
    parameter int BLANK_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SEG_NIB_W*NUM_DIG-1:0] digit_data,
    input  logic [NUM_DIG-1:0]           digit_en,
    input  logic [NUM_DIG-1:0]           dp_in,
    output logic [NUM_DIG-1:0]           seg_sel,
    output logic [SEG_NIB_W-1:0]         bin_data,
    output logic                         bin_en,
    output logic                         dp_out,
    output logic                         frame_start
);

    localparam int SLOT_CYC = CLK_FREQ / (FRAME_HZ * NUM_DIG);
    localparam int CNT_W    = seg_clog2(SLOT_CYC);
    localparam int IDX_W    = seg_clog2(NUM_DIG);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             slot_wrap, frame_wrap;

    seg_scan_timer #(
        .SLOT_CYC (SLOT_CYC),
        .NUM_DIG  (NUM_DIG),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_o        (cnt),
        .idx_o        (idx),
        .slot_wrap_o  (slot_wrap),
        .frame_wrap_o (frame_wrap)
    );

    // First-cycle-of-slot / first-cycle-of-frame flags; both come out of reset set.
    logic slot_first_q, frame_first_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_first_q  <= 1'b1;
            frame_first_q <= 1'b1;
        end else begin
            slot_first_q  <= slot_wrap;
            frame_first_q <= frame_wrap;
        end
    end

    logic [SEG_NIB_W*NUM_DIG-1:0]     snap_data_q, snap_data_d;
    logic [NUM_DIG-1:0]               snap_en_q, snap_en_d;
    logic [NUM_DIG-1:0]               snap_dp_q, snap_dp_d;
    logic [SEG_NIB_W*SEG_MAX_DIG-1:0] data_pad;
    logic                             take;
    logic                             suppress;
    logic                             en_eff;
    seg_phase_e                       phase;

    logic [NUM_DIG-1:0]   seg_sel_q, seg_sel_d;
    logic [SEG_NIB_W-1:0] bin_data_q, bin_data_d;
    logic                 bin_en_q, bin_en_d;
    logic                 dp_out_q, dp_out_d;
    logic                 frame_start_q;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIG-1:0] lz;
    logic               zero_above;
`endif

    // Outputs are built from the next snapshot value so the first slot of a
    // frame already shows the freshly captured data.
    always_comb begin
        take        = frame_first_q;
        snap_data_d = take ? digit_data : snap_data_q;
        snap_en_d   = take ? digit_en   : snap_en_q;
        snap_dp_d   = take ? dp_in      : snap_dp_q;

        data_pad                          = '0;
        data_pad[SEG_NIB_W*NUM_DIG-1:0]   = snap_data_d;

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        zero_above = 1'b1;
        for (int j = NUM_DIG - 1; j >= 0; j--) begin
            zero_above = zero_above & (seg_nib(data_pad, unsigned'(j)) == '0);
            lz[j]      = zero_above;
        end
        suppress = (idx != '0) && lz[idx];
`else
        suppress = 1'b0;
`endif

        en_eff = snap_en_d[idx] & ~suppress;
        // The slot's first cycle is forced blank so adjacent selects never touch.
        phase  = (slot_first_q || (cnt < CNT_W'(BLANK_CYC))) ? PH_BLANK : PH_DRIVE;

        seg_sel_d  = '1;
        bin_en_d   = 1'b0;
        dp_out_d   = 1'b0;
        bin_data_d = seg_nib(data_pad, 32'(idx));
        if (phase == PH_DRIVE && en_eff) begin
            seg_sel_d[idx] = 1'b0;
            bin_en_d       = 1'b1;
            dp_out_d       = snap_dp_d[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_data_q   <= '0;
            snap_en_q     <= '0;
            snap_dp_q     <= '0;
            seg_sel_q     <= '1;
            bin_data_q    <= '0;
            bin_en_q      <= 1'b0;
            dp_out_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            snap_data_q   <= snap_data_d;
            snap_en_q     <= snap_en_d;
            snap_dp_q     <= snap_dp_d;
            seg_sel_q     <= seg_sel_d;
            bin_data_q    <= bin_data_d;
            bin_en_q      <= bin_en_d;
            dp_out_q      <= dp_out_d;
            frame_start_q <= take;
        end
    end

    assign seg_sel     = seg_sel_q;
    assign bin_data    = bin_data_q;
    assign bin_en      = bin_en_q;
    assign dp_out      = dp_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a 4-cycle slot, 6 digits, 1 blank cycle.
module tb_seg_scan_ctrl;

    localparam int ND    = 6;
    localparam int SLOT  = 4;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [23:0]   digit_data;
    logic [ND-1:0] digit_en;
    logic [ND-1:0] dp_in;
    logic [ND-1:0] seg_sel;
    logic [3:0]    bin_data;
    logic          bin_en;
    logic          dp_out;
    logic          frame_start;

    seg_scan_ctrl #(
        .NUM_DIG   (ND),
        .CLK_FREQ  (1200),
        .FRAME_HZ  (50),
        .BLANK_CYC (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_data  (digit_data),
        .digit_en    (digit_en),
        .dp_in       (dp_in),
        .seg_sel     (seg_sel),
        .bin_data    (bin_data),
        .bin_en      (bin_en),
        .dp_out      (dp_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND-1:0] sel;
        logic [3:0]    bin;
        logic          be;
        logic          dp;
        logic          fs;
    } exp_t;

    typedef struct {
        logic [23:0]   data;
        logic [ND-1:0] en;
        logic [ND-1:0] dp;
        logic [ND-1:0] lit;
        int            dpc;
        int            bec;
    } vec_t;

    exp_t          sbq[$];
    vec_t          tv[7];
    int            total = 0;
    int            bad = 0;
    int            t = 0;
    logic [23:0]   m_data = '0;
    logic [ND-1:0] m_en = '0;
    logic [ND-1:0] m_dp = '0;
    logic [ND-1:0] lit;
    int            dp_cnt;
    int            be_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: slot position derived from the edge count since reset.
    task automatic predict();
        exp_t e;
        int   c;
        int   i;
        logic en_e;
        if (!rst_n) begin
            e.sel = '1; e.bin = '0; e.be = 1'b0; e.dp = 1'b0; e.fs = 1'b0;
            t = 0; m_data = '0; m_en = '0; m_dp = '0;
        end else begin
            c = t % SLOT;
            i = (t / SLOT) % ND;
            if (t % FRAME == 0) begin
                m_data = digit_data; m_en = digit_en; m_dp = dp_in;
            end
            en_e = m_en[i];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            if (i != 0 && (m_data >> (4 * i)) == 24'd0) en_e = 1'b0;
`endif
            e.fs  = (t % FRAME == 0);
            e.bin = m_data[4*i +: 4];
            if (c >= 1 && en_e) begin
                e.sel = ~(6'd1 << i); e.be = 1'b1; e.dp = m_dp[i];
            end else begin
                e.sel = '1; e.be = 1'b0; e.dp = 1'b0;
            end
            t++;
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        predict();
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("sb", {19'd0, seg_sel, bin_data, bin_en, dp_out, frame_start},
                        {19'd0, e.sel, e.bin, e.be, e.dp, e.fs});
        end
        lit = lit | ~seg_sel;
        if (dp_out) dp_cnt++;
        if (bin_en) be_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        lit = '0; dp_cnt = 0; be_cnt = 0;
    endtask

    initial begin
        logic [ND-1:0] sel_h[1:6];
        logic [3:0]    bin_h[1:6];
        logic          fs1;
        int            gap;
        int            found;

        tv[0] = '{24'h123456, 6'b111111, 6'b000000, 6'b111111, 0, 18};
        tv[1] = '{24'h123456, 6'b111101, 6'b000001, 6'b111101, 3, 15};
        tv[4] = '{24'hABCDEF, 6'b000000, 6'b111111, 6'b000000, 0, 0};
        tv[6] = '{24'h100000, 6'b010101, 6'b000100, 6'b010101, 3, 9};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        tv[2] = '{24'h000042, 6'b111111, 6'b000000, 6'b000011, 0, 6};
        tv[3] = '{24'h000000, 6'b111111, 6'b000000, 6'b000001, 0, 3};
        tv[5] = '{24'h0F0000, 6'b111111, 6'b110001, 6'b011111, 6, 15};
`else
        tv[2] = '{24'h000042, 6'b111111, 6'b000000, 6'b111111, 0, 18};
        tv[3] = '{24'h000000, 6'b111111, 6'b000000, 6'b111111, 0, 18};
        tv[5] = '{24'h0F0000, 6'b111111, 6'b110001, 6'b111111, 9, 18};
`endif

        digit_data = 24'h123456; digit_en = '1; dp_in = '0;
        lit = '0; dp_cnt = 0; be_cnt = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(seg_sel), 32'h3F);
        check("rst_bin", 32'(bin_data), 32'h0);
        check("rst_flags", {29'd0, bin_en, dp_out, frame_start}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Release: blank edge, three drive edges of digit 0, blank, then digit 1.
        for (int n = 1; n <= 6; n++) begin
            step();
            sel_h[n] = seg_sel;
            bin_h[n] = bin_data;
            if (n == 1) fs1 = frame_start;
        end
        check("edge1_fs", 32'(fs1), 32'h1);
        check("edge1_sel", 32'(sel_h[1]), 32'h3F);
        for (int n = 2; n <= 4; n++) begin
            check("d0_sel", 32'(sel_h[n]), 32'h3E);
            check("d0_bin", 32'(bin_h[n]), 32'h6);
        end
        check("edge5_sel", 32'(sel_h[5]), 32'h3F);
        check("edge6_sel", 32'(sel_h[6]), 32'h3D);
        check("edge6_bin", 32'(bin_h[6]), 32'h5);

        // frame_start period
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            step();
            if (frame_start) found = 1;
        end
        check("fs_seen", 32'(found), 32'h1);
        gap = 0;
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            step();
            gap++;
            if (frame_start) found = 1;
        end
        check("fs_found2", 32'(found), 32'h1);
        check("fs_period", 32'(gap), 32'd24);

        // Mid-frame data change is held off until the next snapshot.
        digit_data = 24'h123456; digit_en = '1; dp_in = '0;
        do_reset();
        for (int n = 1; n <= 13; n++) step();
        digit_data = 24'hABCDEF;
        for (int n = 14; n <= 30; n++) begin
            step();
            case (n)
                14: check("mid_d3", 32'(bin_data), 32'h3);
                18: check("mid_d4", 32'(bin_data), 32'h2);
                22: check("mid_d5", 32'(bin_data), 32'h1);
                26: check("new_d0", 32'(bin_data), 32'hF);
                30: check("new_d1", 32'(bin_data), 32'hE);
                default: ;
            endcase
        end

        // Table: one frame per vector, accumulate what was lit.
        for (int v = 0; v < 7; v++) begin
            digit_data = tv[v].data; digit_en = tv[v].en; dp_in = tv[v].dp;
            do_reset();
            for (int n = 1; n <= FRAME; n++) begin
                step();
                if (v == 1 && n >= 5 && n <= 8) check("v1_slot1_be", 32'(bin_en), 32'h0);
            end
            check($sformatf("v%0d_lit", v), 32'(lit), 32'(tv[v].lit));
            check($sformatf("v%0d_dp", v), 32'(dp_cnt), 32'(tv[v].dpc));
            check($sformatf("v%0d_be", v), 32'(be_cnt), 32'(tv[v].bec));
        end

        // Asynchronous reset while digit 3 is driven.
        digit_data = 24'h123456; digit_en = '1; dp_in = '0;
        do_reset();
        for (int n = 1; n <= 15; n++) step();
        check("pre_rst_sel", 32'(seg_sel), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check("async_sel", 32'(seg_sel), 32'h3F);
        check("async_bin", 32'(bin_data), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("restart_fs", 32'(frame_start), 32'h1);
        check("restart_sel", 32'(seg_sel), 32'h3F);
        step();
        check("restart_d0", 32'(seg_sel), 32'h3E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
